// File: rtl/router_ingress.sv
// Ingress stage of the 1x3 router: header decode, one-entry holding register, FIFO writes, parity check.
// Optional build macro ROUTER_DROP_CNT_EN adds a saturating drop_count output for packets sent to an invalid port.
module router_ingress #(
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [WIDTH-1:0]     dout,
  output logic                 lfd_state,
  output logic                 err,
  output logic                 parity_done
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  // state      | meaning
  // IDLE       | waiting for a header byte
  // WAIT_EMPTY | header held until the destination FIFO is empty
  // PAYLOAD    | accepting payload bytes, folding them into the parity
  // PARITY     | accepting the parity byte
  // DRAIN      | source stalled until the held parity byte is written
  // CHECK      | publish parity result, pulse parity_done
  // DROP       | discarding a packet addressed to an invalid port

  localparam int AW = 2;
  localparam int LW = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_PAYLOAD,
    S_PARITY,
    S_DRAIN,
    S_CHECK,
    S_DROP
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [WIDTH-1:0] hold_reg;
  logic             hold_lfd;
  logic             hold_vld;
  logic [AW-1:0]    dest;
  logic [LW-1:0]    remaining;
  logic [WIDTH-1:0] acc;
  logic             mismatch;
  logic [WIDTH-1:0] dout_last;

  logic [AW-1:0]    hdr_addr;
  logic [LW-1:0]    hdr_len;
  logic             hdr_ok;
  logic             dest_full;
  logic             dest_empty;
  logic             abort;
  logic             accept;
  logic             wr_go;
  logic             load_byte;

  assign hdr_addr   = data_in[AW-1:0];
  assign hdr_len    = data_in[AW +: LW];
  assign hdr_ok     = int'(hdr_addr) < NUM_PORTS;
  assign dest_full  = fifo_full[dest];
  assign dest_empty = fifo_empty[dest];

  // A flush of the active destination abandons the packet; IDLE and DROP own no FIFO.
  assign abort = soft_reset[dest] && (state_q != S_IDLE) && (state_q != S_DROP);

  assign accept = pkt_valid && !busy;

  assign wr_go = hold_vld && !dest_full && !abort &&
                 (state_q != S_WAIT_EMPTY) && (state_q != S_DROP);

  assign load_byte = ((state_q == S_IDLE) && hdr_ok) ||
                     (state_q == S_PAYLOAD) || (state_q == S_PARITY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!hdr_ok)                       state_d = S_DROP;
            else if (!fifo_empty[hdr_addr])    state_d = S_WAIT_EMPTY;
            else if (hdr_len == '0)            state_d = S_PARITY;
            else                               state_d = S_PAYLOAD;
          end
        end
        S_WAIT_EMPTY: begin
          if (dest_empty) state_d = (remaining == '0) ? S_PARITY : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (accept && (remaining == LW'(1))) state_d = S_PARITY;
        end
        S_PARITY: begin
          if (accept) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (!hold_vld) state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = S_IDLE;
        end
        S_DROP: begin
          // remaining was loaded with L, so L+1 bytes pass before it reads zero on an accept
          if (accept && (remaining == '0)) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy        = (hold_vld && dest_full) ||
                  (state_q inside {S_WAIT_EMPTY, S_DRAIN, S_CHECK});
    write_enb   = '0;
    dout        = dout_last;
    lfd_state   = 1'b0;
    parity_done = 1'b0;
    if (wr_go) begin
      write_enb[dest] = 1'b1;
      dout            = hold_reg;
      lfd_state       = hold_lfd;
    end
    if ((state_q == S_CHECK) && !abort) begin
      parity_done = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_lfd  <= 1'b0;
      hold_vld  <= 1'b0;
      dest      <= '0;
      remaining <= '0;
      acc       <= '0;
      mismatch  <= 1'b0;
      err       <= 1'b0;
      dout_last <= '0;
    end else begin
      if (wr_go) begin
        dout_last <= hold_reg;
      end

      // Drain and refill may coincide; the refill wins so throughput stays one byte per cycle.
      if (abort) begin
        hold_vld <= 1'b0;
      end else if (accept && load_byte) begin
        hold_reg <= data_in;
        hold_lfd <= (state_q == S_IDLE);
        hold_vld <= 1'b1;
      end else if (wr_go) begin
        hold_vld <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            remaining <= hdr_len;
            if (hdr_ok) begin
              dest <= hdr_addr;
              acc  <= data_in;
              err  <= 1'b0;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept && !abort) begin
            acc       <= acc ^ data_in;
            remaining <= remaining - LW'(1);
          end
        end
        S_PARITY: begin
          if (accept && !abort) begin
            mismatch <= (data_in != acc);
          end
        end
        S_CHECK: begin
          if (!abort) begin
            err <= mismatch;
          end
        end
        S_DROP: begin
          if (accept) begin
            remaining <= remaining - LW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if ((state_q == S_IDLE) && accept && !hdr_ok && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_ingress.sv
// Self-checking bench for router_ingress: a packet-level model predicts the FIFO write stream,
// parity_done count and err; a per-cycle monitor compares the DUT against it.
module tb_router_ingress;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b1;
  logic [7:0] data_in = 8'hFF;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = 3'b000;
  logic       busy;
  logic [2:0] write_enb;
  logic [7:0] dout;
  logic       lfd_state;
  logic       err;
  logic       parity_done;
`ifdef ROUTER_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  router_ingress dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .soft_reset (soft_reset),
    .busy       (busy),
    .write_enb  (write_enb),
    .dout       (dout),
    .lfd_state  (lfd_state),
    .err        (err),
    .parity_done(parity_done)
`ifdef ROUTER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       lfd;
  } wr_t;

  wr_t  exp_q[$];
  int   wr_cyc[$];
  int   wr_cnt [3] = '{0, 0, 0};
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pd_count = 0;
  int   exp_pd = 0;
  logic exp_err = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int port, input logic [7:0] data, input logic lfd);
    wr_t w;
    w.port = port;
    w.data = data;
    w.lfd  = lfd;
    exp_q.push_back(w);
  endtask

  // Packet-level model: a valid packet appears at its port as header, payload, parity in order.
  task automatic model_pkt(input logic [7:0] hdr, input int n,
                           input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] par);
    logic [7:0] pl [3];
    logic [7:0] x;
    int         port;
    pl[0] = p0; pl[1] = p1; pl[2] = p2;
    port = int'(hdr[1:0]);
    if (port < 3) begin
      x = hdr;
      push_wr(port, hdr, 1'b1);
      for (int i = 0; i < n; i++) begin
        push_wr(port, pl[i], 1'b0);
        x = x ^ pl[i];
      end
      push_wr(port, par, 1'b0);
      exp_pd++;
      exp_err = (par != x);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, output int waited);
    data_in   = b;
    pkt_valid = 1'b1;
    waited    = 0;
    #1;
    while (busy && waited < 200) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (busy) check("accept_timeout", busy, 1'b0);
    @(posedge clock);
    @(negedge clock);
    pkt_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] par, output int hdr_cyc);
    logic [7:0] pl [3];
    int         w;
    pl[0] = p0; pl[1] = p1; pl[2] = p2;
    model_pkt(hdr, n, p0, p1, p2, par);
    send_byte(hdr, w);
    hdr_cyc = cyc;
    for (int i = 0; i < n; i++) send_byte(pl[i], w);
    send_byte(par, w);
  endtask

  task automatic finish_pkt();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clock);
      #3;
      t++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (4) @(negedge clock);
    #3;
    check("parity_done_count", pd_count, exp_pd);
    check("err_model", err, exp_err);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      check("lfd_needs_write", {31'b0, lfd_state && (write_enb == 3'b000)}, 0);
      if (write_enb != 3'b000) begin
        int  p;
        wr_t e;
        p = 0;
        check("write_onehot", $countones(write_enb), 1);
        for (int i = 0; i < 3; i++) if (write_enb[i]) p = i;
        wr_cnt[p]++;
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {29'b0, write_enb}, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_port", p, e.port);
          check("write_data", {24'b0, dout}, {24'b0, e.data});
          check("write_lfd", {31'b0, lfd_state}, {31'b0, e.lfd});
        end
      end
      if (parity_done) pd_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int h;
    int w;
    int base;
    int pdb;
    int tot;

    // reset held for two edges with a live-looking input
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_write_enb", write_enb, 0);
    check("rst_dout", dout, 0);
    check("rst_lfd", lfd_state, 0);
    check("rst_err", err, 0);
    check("rst_parity_done", parity_done, 0);
    reset     = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    @(negedge clock);

    // good packet, back-to-back
    wr_cyc.delete();
    base = wr_cnt[1];
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, h);
    check("good_model_err", exp_err, 1'b0);
    finish_pkt();
    check("good_writes", wr_cnt[1] - base, 5);
    check("good_first_write_cyc", wr_cyc[0], h);
    check("good_last_write_cyc", wr_cyc[4], h + 4);
    check("good_pd_literal", pd_count, 1);
    check("good_err_literal", err, 0);

    // bad parity, sticky, then cleared by the next header
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h00, h);
    check("bad_model_err", exp_err, 1'b1);
    finish_pkt();
    check("bad_err_literal", err, 1);
    repeat (5) @(negedge clock);
    #3;
    check("bad_err_sticky", err, 1);
    model_pkt(8'h04, 1, 8'hAA, 8'h00, 8'h00, 8'hAE);
    send_byte(8'h04, w);
    #1;
    check("err_cleared_by_header", err, 0);
    send_byte(8'hAA, w);
    send_byte(8'hAE, w);
    finish_pkt();
    check("pd_after_three", pd_count, 3);

    // backpressure on port 1 after the second payload write
    base = wr_cnt[1];
    fork
      send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, h);
      begin
        int t;
        t = 0;
        while (wr_cnt[1] < base + 3 && t < 100) begin
          @(negedge clock);
          #3;
          t++;
        end
        check("bp_trigger", {31'b0, wr_cnt[1] >= base + 3}, 1);
        repeat (3) begin
          @(negedge clock);
          fifo_full[1] = 1'b1;
          #3;
          check("bp_busy", busy, 1);
          check("bp_no_write", write_enb, 0);
        end
        @(negedge clock);
        fifo_full[1] = 1'b0;
      end
    join
    finish_pkt();
    check("bp_writes", wr_cnt[1] - base, 5);

    // header waits for an empty FIFO on port 0
    fifo_empty[0] = 1'b0;
    base = wr_cnt[0];
    model_pkt(8'h08, 2, 8'h5A, 8'hA5, 8'h00, 8'hF7);
    send_byte(8'h08, w);
    repeat (4) begin
      @(negedge clock);
      #3;
      check("we_busy", busy, 1);
      check("we_no_write", write_enb, 0);
    end
    @(negedge clock);
    fifo_empty[0] = 1'b1;
    send_byte(8'h5A, w);
    send_byte(8'hA5, w);
    send_byte(8'hF7, w);
    finish_pkt();
    check("we_writes", wr_cnt[0] - base, 4);

    // soft reset while in PAYLOAD: only the header reaches the FIFO
    base = wr_cnt[0];
    pdb  = pd_count;
    push_wr(0, 8'h08, 1'b1);
    send_byte(8'h08, w);
    send_byte(8'h5A, w);
    soft_reset[0] = 1'b1;
    #3;
    check("srst_no_write", write_enb, 0);
    @(negedge clock);
    soft_reset[0] = 1'b0;
    repeat (4) begin
      #3;
      check("srst_idle_busy", busy, 0);
      check("srst_idle_no_write", write_enb, 0);
      @(negedge clock);
    end
    check("srst_writes", wr_cnt[0] - base, 1);
    check("srst_no_pd", pd_count, pdb);
    check("srst_queue", exp_q.size(), 0);
    check("srst_err", err, 0);

    // drop: header to port 3 with L=1, then two bytes
`ifdef ROUTER_DROP_CNT_EN
    check("drop_count_before", drop_count, 0);
`endif
    pdb = pd_count;
    tot = wr_cnt[0] + wr_cnt[1] + wr_cnt[2];
    model_pkt(8'h07, 1, 8'h3C, 8'h00, 8'h00, 8'hC3);
    send_byte(8'h07, w);
    check("drop_hdr_nowait", w, 0);
    send_byte(8'h3C, w);
    check("drop_b1_nowait", w, 0);
    send_byte(8'hC3, w);
    check("drop_b2_nowait", w, 0);
    repeat (3) @(negedge clock);
    #3;
    check("drop_no_pd", pd_count, pdb);
    check("drop_no_writes", wr_cnt[0] + wr_cnt[1] + wr_cnt[2], tot);
`ifdef ROUTER_DROP_CNT_EN
    check("drop_count_after", drop_count, 1);
`endif

    // normal traffic resumes right after the drop
    base = wr_cnt[1];
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, h);
    finish_pkt();
    check("post_drop_writes", wr_cnt[1] - base, 5);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
- Ingress stage of the 1x3 router, directly upstream of the three output FIFOs.
- Accepts the source byte stream (header, payload, parity), decodes the destination, and stalls the source with busy.
- Writes each byte into the selected FIFO with lfd_state marking the header.
- Checks packet parity, flags errors, and drops packets addressed to the invalid port 3.

Parameters:
- WIDTH, 8, data byte width; header layout fixed: [1:0] addr, [7:2] payload length L.
- NUM_PORTS, 3, number of destination FIFOs; addr values >= NUM_PORTS are invalid.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  source presents a valid byte on data_in.
- data_in  in  WIDTH  source byte.
- fifo_full  in  NUM_PORTS  per-FIFO full.
- fifo_empty  in  NUM_PORTS  per-FIFO empty.
- soft_reset  in  NUM_PORTS  per-FIFO flush/timeout; aborts a packet routed to that FIFO.
- busy  out  1  source must hold data_in/pkt_valid while high.
- write_enb  out  NUM_PORTS  one-hot FIFO write strobe.
- dout  out  WIDTH  byte to FIFOs.
- lfd_state  out  1  high with the header write.
- err  out  1  parity mismatch, sticky.
- parity_done  out  1  one-cycle pulse at packet completion.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, hold_vld=0, dest=0, dout=0, write_enb=0, lfd_state=0, busy=0, err=0, parity_done=0, parity accumulator=0.
- Packet format: header, then L payload bytes (L=0..63), then 1 parity byte. Expected parity = XOR of header and all payload bytes.
- Accept rule: a byte is accepted on an edge with pkt_valid=1 and busy=0. Gaps (pkt_valid=0) mid-packet are legal and simply stall.
- One-entry holding register (hold_reg, hold_lfd, hold_vld). An accepted byte is loaded at edge N.
- Write rule: write_enb[dest]=1 in a cycle where hold_vld=1, fifo_full[dest]=0, and state is not WAIT_EMPTY or DROP.
  - In that cycle dout=hold_reg and lfd_state=hold_lfd; the FIFO captures it at edge N+1.
  - Latency is 1 cycle in the best case.
  - dout holds its last value when no write occurs; write_enb is never asserted for more than one port.
- Drain and refill of the holding register in the same cycle is allowed, giving 1 byte/cycle throughput.
- busy = (hold_vld & fifo_full[dest]) | state in {WAIT_EMPTY, DRAIN, CHECK}.
- States:
  - IDLE: accept header.
    - addr >= NUM_PORTS: go to DROP, remaining = L+1, no write.
    - Otherwise latch dest and L, parity acc = header, hold_lfd=1.
    - Then go to WAIT_EMPTY if fifo_empty[addr]=0, else to PAYLOAD (or PARITY if L=0).
  - WAIT_EMPTY: when fifo_empty[dest]=1, go to PAYLOAD (or PARITY if L=0). The header sits in hold until then.
  - PAYLOAD: each accept does acc ^= byte and decrements remaining; after the Lth byte, go to PARITY.
  - PARITY: accept the parity byte (it is written to the FIFO), set mismatch = (byte != acc), go to DRAIN.
  - DRAIN: when hold_vld=0, go to CHECK.
  - CHECK: err <= mismatch, parity_done=1 for one cycle, go to IDLE.
  - DROP: busy=0, accept and discard bytes; when remaining hits 0, go to IDLE. No parity check; err unchanged.
- err is cleared on the next accepted header.
- soft_reset[dest]=1 in any non-IDLE, non-DROP state: next state IDLE, hold_vld=0, no write that cycle, err unchanged, no parity_done. The source is expected to restart the packet.
- reset asserted mid-packet: all state returns to reset values at that edge.
- Counters (remaining) are 6-bit; the acc width is WIDTH bits.

Optional Feature:
- Macro ROUTER_DROP_CNT_EN.
- Defined: adds output drop_count [7:0]. Reset 0. Increments at the edge a DROP-bound header is accepted and saturates at 255.
- Not defined: no port, no counter; drop behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=1 for 2 cycles with pkt_valid=1, data_in=8'hFF -> all outputs 0, no write_enb, busy=0.
- Good packet: header 8'h0D (addr 1, L=3), payload 11,22,33, parity 0D, back-to-back; fifo_empty=3'b111, fifo_full=0.
  - Expect write_enb=3'b010 for 5 consecutive cycles starting 1 cycle after the header, dout 0D,11,22,33,0D.
  - lfd_state=1 only with 0D(header).
  - parity_done pulses once; err=0.
- Bad parity: same packet with parity 8'h00 -> err=1 after CHECK and stays 1; the next header 8'h04 clears it.
- Backpressure: raise fifo_full[1] for 3 cycles after the second payload write -> busy=1 those cycles, no write_enb; the byte order afterwards is unchanged and no byte is lost or duplicated.
- Wait-empty and soft reset:
  - Header 8'h08 to addr 0 with fifo_empty[0]=0 -> busy=1, no write until fifo_empty[0]=1.
  - Repeat, pulsing soft_reset[0] in PAYLOAD -> return to IDLE, no further writes, busy=0.
- Drop: header 8'h07 (addr 3, L=1) then 2 bytes -> 3 accepts, write_enb=0 throughout, no parity_done. With ROUTER_DROP_CNT_EN, drop_count goes 0->1.
